sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-client arbiter sitting directly upstream of `sram_controller` on the 128K×16 async SRAM path. It serialises word read/write requests from a high-bandwidth client (port 0, e.g. video/sprite fetch) and a general client (port 1, e.g. CPU or ROM loader) onto the controller's single-request interface. It uses round-robin fairness, a per-transaction watchdog and a one-cycle ack/response path back to the winning client.

## Interface
- `TIMEOUT_CYCLES`, 255: max cycles in WAIT before the transaction is aborted with an error; range 1..65535.
- `clk`  in  1  system clock; controller and both clients share it.
- `rst`  in  1  reset; synchronous, active-high.
- `p0_req`, `p1_req`  in  1 each  level request; held high until the matching ack.
- `p0_we`, `p1_we`  in  1 each  1 = write, 0 = read; stable while req is high.
- `p0_addr`, `p1_addr`  in  17 each  word address.
- `p0_wdata`, `p1_wdata`  in  16 each  write data.
- `p0_ack`, `p1_ack`  out  1 each  one-cycle completion pulse.
- `p0_rdata`, `p1_rdata`  out  16 each  read data; valid on ack, held until that port's next ack.
- `p0_err`, `p1_err`  out  1 each  qualifies ack; 1 = watchdog timeout.
- `mc_read_req`, `mc_write_req`  out  1 each  to the controller's `read_req`/`write_req`; one-cycle pulse.
- `mc_addr`  out  17  to the controller's `addr_in`.
- `mc_wdata`  out  16  to the controller's `write_data`.
- `mc_rdata`  in  16  from the controller's `read_data`.
- `mc_ready`  in  1  from the controller's `ready`; one-cycle done pulse.
- `timeout_count`  out  8  saturating count of watchdog aborts since reset.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Any req high → latch the winner's we/addr/wdata into `mc_*` and the grant index, then go to ISSUE.
  - Both high → grant the port opposite `last_grant`.
  - One high → grant that port.
- ISSUE:
  - Exactly one of `mc_read_req`/`mc_write_req` is high, per the latched we.
  - Clear the watchdog counter and go to WAIT.
- WAIT:
  - `mc_ready` sampled high → capture `mc_rdata` into the granted port's rdata (reads only; writes leave rdata unchanged), err=0, go to RESP.
  - Otherwise, if the counter equals `TIMEOUT_CYCLES` → err=1, rdata unchanged, increment `timeout_count` (saturating at 255), go to RESP.
  - Otherwise increment the counter.
- RESP:
  - Granted port's ack is high for exactly this cycle; err is valid with it.
  - Set `last_grant` to the granted index and go to IDLE.
- The client must drop req on the edge after it sees ack. IDLE therefore never re-grants a completed request.
- `mc_ready` sampled outside WAIT is ignored. This includes a late pulse after a timeout.
- `mc_addr`/`mc_wdata` hold the latched values from the grant until the next grant.
- Req withdrawn before ack is a protocol violation. The transaction still completes and the ack is still pulsed.
- Reset (any state):
  - State goes to IDLE and `last_grant`=1, so port 0 wins the first tie.
  - All acks, errs, `mc_read_req`, `mc_write_req` go to 0.
  - `mc_addr`, `mc_wdata`, both rdata and `timeout_count` go to 0.
  - No in-flight controller operation is tracked across reset.

## Timing
- Req sampled high at edge E0 (IDLE) → `mc_*_req` high in cycle E0+1 (ISSUE).
- If the controller returns `mc_ready` sampled at edge Ec, ack is high in cycle Ec+1.
- Req-to-ack latency = controller latency + 3 cycles. New grant is possible at the earliest 2 cycles after ack (ack cycle, then IDLE sample).
- Timeout ack occurs `TIMEOUT_CYCLES`+3 cycles after the grant edge.
- Combinational paths: none. Every output is a register.

## Test plan
- Port 0 write 0x1234 to 0x00010 with a behavioural SRAM and real controller:
  - one `mc_write_req` pulse, `mc_addr`=0x00010;
  - `p0_ack` single pulse, `p0_err`=0;
  - SRAM[0x10]=0x1234.
- Port 1 read of 0x00010 after the above → `p1_ack` pulse with `p1_rdata`=0x1234 and `p0_rdata` unchanged.
- Both ports request continuously (p0: writes 0x0A00+n to addr n; p1: reads from addr 0x1F000):
  - grants strictly alternate p0,p1,p0,… starting with p0;
  - no port waits more than one foreign transaction.
- Controller stub never pulses ready, `TIMEOUT_CYCLES`=4, p1 read:
  - `p1_ack` with `p1_err`=1 exactly 7 cycles after the grant edge;
  - `timeout_count`=1;
  - a late `mc_ready` 3 cycles later produces no ack.
- Assert `rst` for one cycle while in WAIT:
  - next cycle all outputs are 0 and state is IDLE;
  - the following p0 and p1 simultaneous request grants p0 first.
- Force 300 timeouts → `timeout_count` saturates at 255.

Source files
------------

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Two-client round-robin arbiter in front of the async SRAM controller.
// Port 0 is the high-bandwidth client (video/sprite fetch), port 1 the
// general client (CPU / ROM loader). One word transaction is in flight at a
// time. Each transaction is bounded by a watchdog; on expiry the client gets
// an ack qualified by err=1.
//
// Parameters
//   TIMEOUT_CYCLES  cycles spent in WAIT before the transaction is aborted
//                   (1..65535)
//
// Ports
//   clk, rst              shared clock, synchronous active-high reset
//   pN_req                level request, held until the matching ack
//   pN_we                 1 = write, 0 = read
//   pN_addr / pN_wdata    17-bit word address / 16-bit write data
//   pN_ack                one-cycle completion pulse
//   pN_err                qualifies pN_ack, 1 = watchdog abort
//   pN_rdata              read data, valid on ack, held until that port's
//                         next ack
//   mc_read_req           one-cycle request pulse to the controller
//   mc_write_req          one-cycle request pulse to the controller
//   mc_addr / mc_wdata    latched at grant, held until the next grant
//   mc_rdata / mc_ready   controller response; ready is a one-cycle pulse
//   timeout_count         saturating count of watchdog aborts since reset
//
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [16:0] p0_addr,
    input  logic [15:0] p0_wdata,
    output logic        p0_ack,
    output logic [15:0] p0_rdata,
    output logic        p0_err,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [16:0] p1_addr,
    input  logic [15:0] p1_wdata,
    output logic        p1_ack,
    output logic [15:0] p1_rdata,
    output logic        p1_err,

    output logic        mc_read_req,
    output logic        mc_write_req,
    output logic [16:0] mc_addr,
    output logic [15:0] mc_wdata,
    input  logic [15:0] mc_rdata,
    input  logic        mc_ready,

    output logic [7:0]  timeout_count
);

    // The watchdog counter is 16 bits wide, enough for the full
    // TIMEOUT_CYCLES range.
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Client-side views, indexed by port number
    // -------------------------------------------------------------------------
    logic [1:0]       req_vec;
    logic [1:0]       we_vec;
    logic [1:0][16:0] addr_vec;
    logic [1:0][15:0] wdata_vec;

    assign req_vec   = {p1_req, p0_req};
    assign we_vec    = {p1_we, p0_we};
    assign addr_vec  = {p1_addr, p0_addr};
    assign wdata_vec = {p1_wdata, p0_wdata};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_q,         state_d;
    logic             grant_q,         grant_d;
    logic             last_grant_q,    last_grant_d;
    logic             we_q,            we_d;
    logic             mc_read_req_q,   mc_read_req_d;
    logic             mc_write_req_q,  mc_write_req_d;
    logic [16:0]      mc_addr_q,       mc_addr_d;
    logic [15:0]      mc_wdata_q,      mc_wdata_d;
    logic [15:0]      wdog_q,          wdog_d;
    logic [7:0]       timeout_count_q, timeout_count_d;
    logic [1:0]       ack_q,           ack_d;
    logic [1:0]       err_q,           err_d;
    logic [1:0][15:0] rdata_q,         rdata_d;

    // -------------------------------------------------------------------------
    // Round-robin pick
    // -------------------------------------------------------------------------
    // On a tie the port that did not win last time is chosen. With a single
    // request, that port wins; req_vec[1] is then the index directly.
    logic win_valid;
    logic win_idx;

    always_comb begin
        win_valid = |req_vec;
        if (req_vec == 2'b11) begin
            win_idx = ~last_grant_q;
        end else begin
            win_idx = req_vec[1];
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_grant_d    = last_grant_q;
        we_d            = we_q;
        mc_read_req_d   = 1'b0;
        mc_write_req_d  = 1'b0;
        mc_addr_d       = mc_addr_q;
        mc_wdata_d      = mc_wdata_q;
        wdog_d          = wdog_q;
        timeout_count_d = timeout_count_q;
        ack_d           = 2'b00;
        err_d           = 2'b00;
        rdata_d         = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    grant_d    = win_idx;
                    we_d       = we_vec[win_idx];
                    mc_addr_d  = addr_vec[win_idx];
                    mc_wdata_d = wdata_vec[win_idx];
                    // The request pulse is registered on the grant edge so
                    // that it is high for exactly the ISSUE cycle.
                    mc_read_req_d  = ~we_vec[win_idx];
                    mc_write_req_d = we_vec[win_idx];
                    state_d        = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                wdog_d  = 16'd0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // A real completion beats the watchdog if both land on the
                // same edge.
                if (mc_ready) begin
                    if (!we_q) begin
                        rdata_d[grant_q] = mc_rdata;
                    end
                    ack_d[grant_q] = 1'b1;
                    state_d        = ST_RESP;
                end else if (wdog_q == TIMEOUT_LIMIT) begin
                    ack_d[grant_q] = 1'b1;
                    err_d[grant_q] = 1'b1;
                    if (timeout_count_q != 8'hFF) begin
                        timeout_count_d = timeout_count_q + 8'd1;
                    end
                    state_d = ST_RESP;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end

            ST_RESP: begin
                // Ack is visible this cycle. The client drops req on the
                // next edge, so the following IDLE sample cannot see the
                // completed request.
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            grant_q         <= 1'b0;
            // Pretend port 1 won last, so port 0 takes the first tie.
            last_grant_q    <= 1'b1;
            we_q            <= 1'b0;
            mc_read_req_q   <= 1'b0;
            mc_write_req_q  <= 1'b0;
            mc_addr_q       <= 17'd0;
            mc_wdata_q      <= 16'd0;
            wdog_q          <= 16'd0;
            timeout_count_q <= 8'd0;
            ack_q           <= 2'b00;
            err_q           <= 2'b00;
            rdata_q         <= '0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            last_grant_q    <= last_grant_d;
            we_q            <= we_d;
            mc_read_req_q   <= mc_read_req_d;
            mc_write_req_q  <= mc_write_req_d;
            mc_addr_q       <= mc_addr_d;
            mc_wdata_q      <= mc_wdata_d;
            wdog_q          <= wdog_d;
            timeout_count_q <= timeout_count_d;
            ack_q           <= ack_d;
            err_q           <= err_d;
            rdata_q         <= rdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign p0_ack        = ack_q[0];
    assign p1_ack        = ack_q[1];
    assign p0_err        = err_q[0];
    assign p1_err        = err_q[1];
    assign p0_rdata      = rdata_q[0];
    assign p1_rdata      = rdata_q[1];
    assign mc_read_req   = mc_read_req_q;
    assign mc_write_req  = mc_write_req_q;
    assign mc_addr       = mc_addr_q;
    assign mc_wdata      = mc_wdata_q;
    assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//
// Directed bench for sram_arbiter. A small behavioural controller with
// programmable latency (or a dead mode that never answers) sits behind the
// arbiter, with a 128K x 16 SRAM array.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [16:0] p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic        p0_ack, p1_ack, p0_err, p1_err;
    logic [15:0] p0_rdata, p1_rdata;
    logic        mc_read_req, mc_write_req;
    logic [16:0] mc_addr;
    logic [15:0] mc_wdata;
    logic [15:0] mc_rdata;
    logic        mc_ready;
    logic [7:0]  timeout_count;

    always #5 clk = ~clk;

    sram_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .p0_req       (p0_req),
        .p0_we        (p0_we),
        .p0_addr      (p0_addr),
        .p0_wdata     (p0_wdata),
        .p0_ack       (p0_ack),
        .p0_rdata     (p0_rdata),
        .p0_err       (p0_err),
        .p1_req       (p1_req),
        .p1_we        (p1_we),
        .p1_addr      (p1_addr),
        .p1_wdata     (p1_wdata),
        .p1_ack       (p1_ack),
        .p1_rdata     (p1_rdata),
        .p1_err       (p1_err),
        .mc_read_req  (mc_read_req),
        .mc_write_req (mc_write_req),
        .mc_addr      (mc_addr),
        .mc_wdata     (mc_wdata),
        .mc_rdata     (mc_rdata),
        .mc_ready     (mc_ready),
        .timeout_count(timeout_count)
    );

    // -------------------------------------------------------------------------
    // Behavioural controller + SRAM
    // Request seen at edge R, ready pulsed high after edge R+1+ctl_lat.
    // Writes drive junk on mc_rdata so that the bench can catch a port's
    // rdata wrongly updating on a write.
    // -------------------------------------------------------------------------
    logic [15:0] sram [0:131071];
    int          ctl_lat    = 0;
    bit          ctl_dead   = 1'b0;
    bit          late_pulse = 1'b0;
    logic        ctl_busy;
    int          ctl_cnt;
    logic        ctl_we;
    logic [16:0] ctl_addr;
    logic [15:0] ctl_wd;

    always @(posedge clk) begin
        if (rst) begin
            mc_ready           <= 1'b0;
            mc_rdata           <= 16'h0000;
            ctl_busy           <= 1'b0;
            ctl_cnt            <= 0;
            sram[17'h1F000]    <= 16'hBEEF;
        end else begin
            mc_ready <= late_pulse;
            if (ctl_busy) begin
                if (ctl_cnt == 0) begin
                    mc_ready <= 1'b1;
                    ctl_busy <= 1'b0;
                    if (ctl_we) begin
                        sram[ctl_addr] <= ctl_wd;
                        mc_rdata       <= 16'hDEAD;
                    end else begin
                        mc_rdata <= sram[ctl_addr];
                    end
                end else begin
                    ctl_cnt <= ctl_cnt - 1;
                end
            end else if (!ctl_dead && (mc_read_req || mc_write_req)) begin
                ctl_busy <= 1'b1;
                ctl_cnt  <= ctl_lat;
                ctl_we   <= mc_write_req;
                ctl_addr <= mc_addr;
                ctl_wd   <= mc_wdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Monitor (samples on the falling edge)
    // -------------------------------------------------------------------------
    int          rd_pulses = 0;
    int          wr_pulses = 0;
    int          ack0_cnt  = 0;
    int          ack1_cnt  = 0;
    logic [16:0] pulse_addr  = '0;
    logic [15:0] pulse_wdata = '0;
    int          ack_log[$];

    always @(negedge clk) begin
        if (mc_read_req)  rd_pulses++;
        if (mc_write_req) wr_pulses++;
        if (mc_read_req || mc_write_req) begin
            pulse_addr  = mc_addr;
            pulse_wdata = mc_wdata;
        end
        if (p0_ack) begin ack0_cnt++; ack_log.push_back(0); end
        if (p1_ack) begin ack1_cnt++; ack_log.push_back(1); end
    end

    // -------------------------------------------------------------------------
    // Checking helpers
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " p0_ack"},        32'(p0_ack),        32'd0);
        check({tag, " p1_ack"},        32'(p1_ack),        32'd0);
        check({tag, " p0_err"},        32'(p0_err),        32'd0);
        check({tag, " p1_err"},        32'(p1_err),        32'd0);
        check({tag, " mc_read_req"},   32'(mc_read_req),   32'd0);
        check({tag, " mc_write_req"},  32'(mc_write_req),  32'd0);
        check({tag, " mc_addr"},       32'(mc_addr),       32'd0);
        check({tag, " mc_wdata"},      32'(mc_wdata),      32'd0);
        check({tag, " p0_rdata"},      32'(p0_rdata),      32'd0);
        check({tag, " p1_rdata"},      32'(p1_rdata),      32'd0);
        check({tag, " timeout_count"}, 32'(timeout_count), 32'd0);
    endtask

    task automatic set_port(input bit port, input bit req, input bit we,
                            input logic [16:0] a, input logic [15:0] d);
        if (port == 1'b0) begin
            p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
        end else begin
            p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
        end
    endtask

    // Raise req, wait (bounded) for this port's ack, drop req right after,
    // then let one more edge pass so the arbiter is back in IDLE.
    // lat_edges counts edges from the first sampling edge (1) to the ack edge.
    task automatic do_txn(input bit port, input bit we, input logic [16:0] addr,
                          input logic [15:0] wd, output bit got_ack,
                          output bit got_err, output int lat_edges);
        got_ack   = 1'b0;
        got_err   = 1'b0;
        lat_edges = 0;
        set_port(port, 1'b1, we, addr, wd);
        for (int n = 1; n <= 200 && !got_ack; n++) begin
            @(posedge clk); #1;
            if ((port ? p1_ack : p0_ack) == 1'b1) begin
                got_ack   = 1'b1;
                got_err   = port ? p1_err : p0_err;
                lat_edges = n;
            end
        end
        set_port(port, 1'b0, we, addr, wd);
        @(posedge clk); #1;
    endtask

    // -------------------------------------------------------------------------
    // Vector table
    // -------------------------------------------------------------------------
    typedef struct {
        bit          port;
        bit          we;
        logic [16:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic [15:0] exp_r0;
        logic [15:0] exp_r1;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bit ga, ge;
        int gl, rd0, wr0, a0, a1, own, other, start, seen;

        vecs[0] = '{1'b0, 1'b1, 17'h00010, 16'h1234, 1, 16'h0000, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, 17'h00010, 16'h0000, 0, 16'h0000, 16'h1234};
        vecs[2] = '{1'b0, 1'b0, 17'h00010, 16'h0000, 2, 16'h1234, 16'h1234};
        vecs[3] = '{1'b1, 1'b1, 17'h1FFFF, 16'h5A5A, 3, 16'h1234, 16'h1234};
        vecs[4] = '{1'b0, 1'b0, 17'h1FFFF, 16'h0000, 3, 16'h5A5A, 16'h1234};
        vecs[5] = '{1'b1, 1'b0, 17'h1F000, 16'h0000, 0, 16'h5A5A, 16'hBEEF};
        vecs[6] = '{1'b0, 1'b1, 17'h00000, 16'hFFFF, 0, 16'h5A5A, 16'hBEEF};
        vecs[7] = '{1'b1, 1'b0, 17'h00000, 16'h0000, 1, 16'h5A5A, 16'hFFFF};

        rst = 1'b1;
        set_port(1'b0, 1'b0, 1'b0, 17'd0, 16'd0);
        set_port(1'b1, 1'b0, 1'b0, 17'd0, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // ---- table-driven single-port transactions ----
        for (int i = 0; i < 8; i++) begin
            ctl_dead = 1'b0;
            ctl_lat  = vecs[i].lat;
            rd0 = rd_pulses; wr0 = wr_pulses; a0 = ack0_cnt; a1 = ack1_cnt;
            do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, ga, ge, gl);
            own   = vecs[i].port ? (ack1_cnt - a1) : (ack0_cnt - a0);
            other = vecs[i].port ? (ack0_cnt - a0) : (ack1_cnt - a1);
            check($sformatf("v%0d ack", i),        32'(ga), 32'd1);
            check($sformatf("v%0d err", i),        32'(ge), 32'd0);
            check($sformatf("v%0d latency", i),    32'(gl), 32'(vecs[i].lat + 4));
            check($sformatf("v%0d own_acks", i),   32'(own), 32'd1);
            check($sformatf("v%0d other_acks", i), 32'(other), 32'd0);
            check($sformatf("v%0d wr_pulses", i),  32'(wr_pulses - wr0), 32'(vecs[i].we));
            check($sformatf("v%0d rd_pulses", i),  32'(rd_pulses - rd0), 32'(!vecs[i].we));
            check($sformatf("v%0d mc_addr", i),    32'(pulse_addr), 32'(vecs[i].addr));
            if (vecs[i].we)
                check($sformatf("v%0d mc_wdata", i), 32'(pulse_wdata), 32'(vecs[i].wdata));
            check($sformatf("v%0d p0_rdata", i),   32'(p0_rdata), 32'(vecs[i].exp_r0));
            check($sformatf("v%0d p1_rdata", i),   32'(p1_rdata), 32'(vecs[i].exp_r1));
            $display("vec %0d: port %0d we %0d addr %05h ack %0d err %0d lat %0d r0 %04h r1 %04h",
                     i, vecs[i].port, vecs[i].we, vecs[i].addr, ga, ge, gl, p0_rdata, p1_rdata);
        end
        check("sram[0x10]",    32'(sram[17'h00010]), 32'h1234);
        check("sram[0x1FFFF]", 32'(sram[17'h1FFFF]), 32'h5A5A);

        // ---- both ports continuously requesting: strict alternation ----
        ctl_lat = 1;
        start   = ack_log.size();
        fork
            begin
                bit g0, e0; int l0;
                for (int k = 0; k < 4; k++) begin
                    do_txn(1'b0, 1'b1, 17'(k), 16'h0A00 + 16'(k), g0, e0, l0);
                    check($sformatf("alt p0[%0d] ack", k), 32'(g0), 32'd1);
                    check($sformatf("alt p0[%0d] err", k), 32'(e0), 32'd0);
                    $display("alt p0 txn %0d: ack %0d err %0d lat %0d", k, g0, e0, l0);
                end
            end
            begin
                bit g1, e1; int l1;
                for (int k = 0; k < 4; k++) begin
                    do_txn(1'b1, 1'b0, 17'h1F000, 16'h0000, g1, e1, l1);
                    check($sformatf("alt p1[%0d] ack", k), 32'(g1), 32'd1);
                    check($sformatf("alt p1[%0d] rdata", k), 32'(p1_rdata), 32'hBEEF);
                    $display("alt p1 txn %0d: ack %0d err %0d lat %0d rdata %04h", k, g1, e1, l1, p1_rdata);
                end
            end
        join
        check("alt ack count", 32'(ack_log.size() - start), 32'd8);
        for (int j = 0; j < 8 && start + j < ack_log.size(); j++)
            check($sformatf("alt order[%0d]", j), 32'(ack_log[start + j]), 32'(j % 2));
        for (int k = 0; k < 4; k++)
            check($sformatf("alt sram[%0d]", k), 32'(sram[k]), 32'h0A00 + 32'(k));

        // ---- watchdog timeout on p1, then a late ready ----
        ctl_dead = 1'b1;
        do_txn(1'b1, 1'b0, 17'h00123, 16'h0000, ga, ge, gl);
        check("tmo ack",           32'(ga), 32'd1);
        check("tmo err",           32'(ge), 32'd1);
        check("tmo latency",       32'(gl), 32'(TMO + 3));
        check("tmo timeout_count", 32'(timeout_count), 32'd1);
        check("tmo p1_rdata",      32'(p1_rdata), 32'hBEEF);
        $display("timeout txn: ack %0d err %0d lat %0d count %0d", ga, ge, gl, timeout_count);
        // do_txn already consumed one edge after the ack
        repeat (2) @(posedge clk);
        #1;
        late_pulse = 1'b1;
        a0 = ack0_cnt; a1 = ack1_cnt; rd0 = rd_pulses; wr0 = wr_pulses;
        @(posedge clk); #1;
        late_pulse = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("late p0 acks",      32'(ack0_cnt - a0), 32'd0);
        check("late p1 acks",      32'(ack1_cnt - a1), 32'd0);
        check("late mc pulses",    32'((rd_pulses - rd0) + (wr_pulses - wr0)), 32'd0);
        check("late timeout_count", 32'(timeout_count), 32'd1);
        $display("late ready: extra acks %0d", (ack0_cnt - a0) + (ack1_cnt - a1));

        // ---- p0 completes so last_grant=0, then reset while in WAIT ----
        ctl_dead = 1'b0;
        ctl_lat  = 0;
        do_txn(1'b0, 1'b0, 17'h00010, 16'h0000, ga, ge, gl);
        check("pre-rst ack",   32'(ga), 32'd1);
        check("pre-rst rdata", 32'(p0_rdata), 32'h1234);
        $display("pre-reset p0 read: ack %0d rdata %04h", ga, p0_rdata);

        ctl_dead = 1'b1;
        set_port(1'b0, 1'b1, 1'b0, 17'h00055, 16'h7777);
        seen = 0;
        for (int n = 0; n < 20 && seen == 0; n++) begin
            @(posedge clk); #1;
            if (mc_read_req) seen = 1;
        end
        check("rst-wait issue seen", 32'(seen), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        set_port(1'b0, 1'b0, 1'b0, 17'h00055, 16'h7777);
        @(posedge clk); #1;
        check_all_zero("rst-in-wait");
        rst      = 1'b0;
        ctl_dead = 1'b0;
        start    = ack_log.size();
        fork
            begin
                bit g0, e0; int l0;
                do_txn(1'b0, 1'b0, 17'h00010, 16'h0000, g0, e0, l0);
                check("post-rst p0 ack", 32'(g0), 32'd1);
            end
            begin
                bit g1, e1; int l1;
                do_txn(1'b1, 1'b0, 17'h00010, 16'h0000, g1, e1, l1);
                check("post-rst p1 ack", 32'(g1), 32'd1);
            end
        join
        check("post-rst ack count", 32'(ack_log.size() - start), 32'd2);
        if (ack_log.size() > start)
            check("post-rst first grant", 32'(ack_log[start]), 32'd0);
        $display("post-reset tie: %0d acks, first port %0d",
                 ack_log.size() - start, (ack_log.size() > start) ? ack_log[start] : -1);

        // ---- timeout_count saturation ----
        ctl_dead = 1'b1;
        for (int i = 0; i < 300; i++) begin
            do_txn(1'(i % 2), 1'b0, 17'(i), 16'h0000, ga, ge, gl);
            if (i == 253) check("sat count@254", 32'(timeout_count), 32'd254);
            if (i == 254) check("sat count@255", 32'(timeout_count), 32'd255);
        end
        check("sat last err",   32'(ge), 32'd1);
        check("sat final count", 32'(timeout_count), 32'd255);
        $display("saturation: 300 timeouts, timeout_count %0d", timeout_count);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
